// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state type
package uart_pkg;

    localparam int BAUD_DIV_DEFAULT = 5208;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop RX synchroniser with previous-value flop for edge detection
module rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Flops reset high so an idle line never looks like a start edge out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= rx;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rx_s = sync;
    assign fall = prev & ~sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with centre sampling, sticky rdy and framing error flag
module uart_rx #(
    parameter int BAUD_DIV = uart_pkg::BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err
);

    import uart_pkg::*;

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);

    logic rx_s;
    logic fall;

    rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (RX),
        .rx_s (rx_s),
        .fall (fall)
    );

    rx_state_t     state,   state_next;
    logic [CW-1:0] cnt,     cnt_next;
    logic [3:0]    bit_cnt, bit_next;
    logic [7:0]    shift,   shift_next;
    logic [7:0]    data_next;
    logic          rdy_next;
    logic          err_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            rx_data <= '0;
            rdy     <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_cnt <= bit_next;
            shift   <= shift_next;
            rx_data <= data_next;
            rdy     <= rdy_next;
            frm_err <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bit_next   = bit_cnt;
        shift_next = shift;
        data_next  = rx_data;
        err_next   = frm_err;
        rdy_next   = rdy & ~clr_rdy;
        case (state)
            IDLE: begin
                if (fall) begin
                    cnt_next   = HALF;
                    rdy_next   = 1'b0;
                    state_next = START;
                end
            end
            START: begin
                if (cnt == '0) begin
                    // A start bit that is high again at its centre was a glitch.
                    if (rx_s) begin
                        state_next = IDLE;
                    end else begin
                        cnt_next   = FULL;
                        bit_next   = 4'd0;
                        state_next = DATA;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    shift_next = {rx_s, shift[7:1]};
                    cnt_next   = FULL;
                    bit_next   = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    data_next  = shift;
                    state_next = IDLE;
                    // Setting rdy overrides a simultaneous clr_rdy.
                    if (rx_s) begin
                        rdy_next = 1'b1;
                        err_next = 1'b0;
                    end else begin
                        err_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with a behavioural serial transmitter model
module tb_uart_rx;

    import uart_pkg::*;

    localparam int D  = 16;
    localparam int DB = BAUD_DIV_DEFAULT;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       RX      = 1'b1;
    logic       clr_rdy = 1'b0;
    logic       rx_big  = 1'b1;
    logic       clr_big = 1'b0;
    logic [7:0] rx_data;
    logic [7:0] rx_data_big;
    logic       rdy;
    logic       frm_err;
    logic       rdy_big;
    logic       frm_err_big;

    always #10 clk = ~clk;

    uart_rx #(.BAUD_DIV(D)) dut (
        .clk     (clk),
        .rst     (rst),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err)
    );

    uart_rx #(.BAUD_DIV(DB)) dut_big (
        .clk     (clk),
        .rst     (rst),
        .RX      (rx_big),
        .clr_rdy (clr_big),
        .rx_data (rx_data_big),
        .rdy     (rdy_big),
        .frm_err (frm_err_big)
    );

    int         errors = 0;
    int         checks = 0;
    logic [8:0] sb_q[$];
    event       frame_start;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Serial frame as a transmitter with clock scaled by pm/1000 would produce it.
    task automatic send_frame(input logic [7:0] b, input bit good, input int pm, input bit big);
        logic [9:0] bits;
        int         div;
        int         prev_edge;
        int         nb;
        bits      = {good, b, 1'b0};
        div       = big ? DB : D;
        prev_edge = 0;
        if (!big) sb_q.push_back({~good, b});
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (big) rx_big = bits[k];
            else     RX     = bits[k];
            if (k == 0 && !big) -> frame_start;
            nb = ((k + 1) * div * pm + 500) / 1000;
            repeat (nb - prev_edge - 1) @(negedge clk);
            prev_edge = nb;
        end
        @(negedge clk);
        if (big) rx_big = 1'b1;
        else     RX     = 1'b1;
    endtask

    logic       rdy_prev = 1'b0;
    logic       err_prev = 1'b0;
    logic [8:0] exp_e;

    always @(negedge clk) begin
        if (!rst) begin
            if (rdy && !rdy_prev) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rdy: got data %0h with empty scoreboard", rx_data);
                end else begin
                    exp_e = sb_q.pop_front();
                    check("rdy_data", {24'd0, rx_data}, {24'd0, exp_e[7:0]});
                    check("rdy_frm_err", {31'd0, frm_err}, {31'd0, exp_e[8]});
                end
            end
            if (frm_err && !err_prev) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frm_err: got data %0h with empty scoreboard", rx_data);
                end else begin
                    exp_e = sb_q.pop_front();
                    check("err_data", {24'd0, rx_data}, {24'd0, exp_e[7:0]});
                    check("err_expected", {31'd0, exp_e[8]}, 32'd1);
                    check("err_rdy", {31'd0, rdy}, 32'd0);
                end
            end
        end
        rdy_prev = rdy;
        err_prev = frm_err;
    end

    int         lat = 155;
    int         cyc;
    bit         prev_bad;
    bit         bad;
    logic [7:0] rb;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_rx_data", {24'd0, rx_data}, 32'h0);
        check("reset_rdy", {31'd0, rdy}, 32'd0);
        check("reset_frm_err", {31'd0, frm_err}, 32'd0);
        check("reset_state", {30'd0, dut.state}, {30'd0, IDLE});
        rst = 1'b0;
        repeat (2 * D) @(negedge clk);

        // A5 with latency measurement, then clr_rdy
        fork
            send_frame(8'hA5, 1'b1, 1000, 1'b0);
            begin
                @(frame_start);
                cyc = 0;
                while (cyc < 400 && !rdy) begin
                    @(posedge clk);
                    #1;
                    cyc++;
                end
                checks++;
                if (cyc < 154 || cyc > 156) begin
                    errors++;
                    $display("FAIL a5_latency: got %0d cycles expected 154..156", cyc);
                end else begin
                    lat = cyc;
                end
                check("a5_data", {24'd0, rx_data}, 32'hA5);
                check("a5_frm_err", {31'd0, frm_err}, 32'd0);
                clr_rdy = 1'b1;
                @(posedge clk);
                #1;
                clr_rdy = 1'b0;
                check("a5_clr_rdy", {31'd0, rdy}, 32'd0);
            end
        join
        repeat (D) @(negedge clk);

        // back-to-back loopback bytes
        send_frame(8'h00, 1'b1, 1000, 1'b0);
        send_frame(8'hFF, 1'b1, 1000, 1'b0);
        send_frame(8'h55, 1'b1, 1000, 1'b0);
        send_frame(8'h80, 1'b1, 1000, 1'b0);
        repeat (D) @(negedge clk);
        check("b2b_last_data", {24'd0, rx_data}, 32'h80);

        // glitch shorter than half a bit
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        RX = 1'b0;
        repeat (D / 4) @(negedge clk);
        RX = 1'b1;
        repeat (2 * D) @(negedge clk);
        check("glitch_rdy", {31'd0, rdy}, 32'd0);
        check("glitch_data", {24'd0, rx_data}, 32'h80);
        check("glitch_state", {30'd0, dut.state}, {30'd0, IDLE});

        // framing error then recovery
        send_frame(8'h3C, 1'b0, 1000, 1'b0);
        check("ferr_flag", {31'd0, frm_err}, 32'd1);
        check("ferr_rdy", {31'd0, rdy}, 32'd0);
        check("ferr_data", {24'd0, rx_data}, 32'h3C);
        repeat (D) @(negedge clk);
        send_frame(8'h12, 1'b1, 1000, 1'b0);
        check("recover_frm_err", {31'd0, frm_err}, 32'd0);
        check("recover_rdy", {31'd0, rdy}, 32'd1);

        // reset after data bit 3 of C3
        repeat (D) @(negedge clk);
        RX = 1'b0;
        repeat (D) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            RX = (8'hC3 >> i) & 8'h01;
            repeat (D) @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check("midrst_data", {24'd0, rx_data}, 32'h0);
        check("midrst_rdy", {31'd0, rdy}, 32'd0);
        check("midrst_frm_err", {31'd0, frm_err}, 32'd0);
        RX = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * D) @(negedge clk);
        send_frame(8'hC3, 1'b1, 1000, 1'b0);
        check("after_rst_data", {24'd0, rx_data}, 32'hC3);

        // clr_rdy in the same cycle rdy is set
        repeat (D) @(negedge clk);
        fork
            send_frame(8'h69, 1'b1, 1000, 1'b0);
            begin
                @(frame_start);
                repeat (lat - 1) @(posedge clk);
                #1;
                clr_rdy = 1'b1;
                @(posedge clk);
                #1;
                clr_rdy = 1'b0;
                check("clr_same_cycle_rdy", {31'd0, rdy}, 32'd1);
            end
        join

        // randomized frames with baud skew
        prev_bad = 1'b1;
        for (int n = 0; n < 24; n++) begin
            rb  = 8'($urandom);
            bad = !prev_bad && ($urandom_range(0, 4) == 0);
            send_frame(rb, !bad, int'($urandom_range(980, 1020)), 1'b0);
            prev_bad = bad;
            repeat ($urandom_range(0, D)) @(negedge clk);
        end

        for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);

        // full-rate divider
        check("big_reset_rdy", {31'd0, rdy_big}, 32'd0);
        rb = 8'($urandom);
        send_frame(rb, 1'b1, 1000, 1'b1);
        check("big_rdy", {31'd0, rdy_big}, 32'd1);
        check("big_data", {24'd0, rx_data_big}, {24'd0, rb});
        check("big_frm_err", {31'd0, frm_err_big}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

- Serial receiver counterpart to the team's 8N1 UART transmitter: 1 start bit (low), 8 data bits LSB-first, 1 stop bit (high), 9600 baud from a 50 MHz clock.
- Synchronises the asynchronous RX pin, finds each start bit and samples every bit at its centre.
- Presents the received byte with a sticky ready flag that downstream logic clears.
- Sits at the serial input of the command path, mirroring the transmitter on the output side.

## Interface
- BAUD_DIV, 5208: clock cycles per bit; must be ≥ 4 and even.
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- RX  input  1  serial line; asynchronous to clk; idles high.
- clr_rdy  input  1  single-cycle pulse; clears rdy.
- rx_data  output  8  last received byte; held until the next byte completes.
- rdy  output  1  byte available; sticky until cleared.
- frm_err  output  1  last frame had stop bit = 0; sticky until next frame completes.

## Operation
- RX passes through two flops, then a third flop holds the previous value. All three reset to 1.
- Falling edge = previous synced value 1 and current synced value 0.
- Baud counter: down-counter, width $clog2(BAUD_DIV). The shift register collects bits in at the MSB and shifts right. The bit counter is 4 bits.
- FSM states, enum rx_state_t:
  - IDLE: on a falling edge, load the counter with BAUD_DIV/2 - 1, clear rdy, and go to START.
  - START: when the counter reaches 0, sample the synced RX.
    - Sample = 1 (glitch): return to IDLE; outputs unchanged apart from rdy already being cleared.
    - Sample = 0: load the counter with BAUD_DIV - 1, clear the bit counter, and go to DATA.
  - DATA: at each counter zero, shift the sample into bit 7, reload the counter, and increment the bit counter. After the 8th sample, go to STOP.
  - STOP: at counter zero, sample the stop bit, then go to IDLE.
    - Stop bit = 1: rx_data takes the shift register, rdy goes to 1, frm_err goes to 0.
    - Stop bit = 0: rx_data takes the shift register, frm_err goes to 1, rdy stays 0.
- Line held low (break) after a framing error: no new frame starts until RX has been seen high and then falls again.
- clr_rdy clears rdy in any state.
- clr_rdy in the same cycle as rdy being set: set wins.
- clr_rdy has no effect on frm_err or rx_data.

## Timing
- Reset values:
  - rx_data = 8'h00, rdy = 0, frm_err = 0.
  - FSM in IDLE, counters at 0, synchroniser flops at 1.
- Reset is honoured immediately and at any point, including mid-frame. The partial frame is discarded with no rdy pulse.
- Let E be the cycle a falling edge is detected. E is 2–3 clk cycles after the pin edge.
- Samples, relative to E:
  - start bit at E + BAUD_DIV/2;
  - data bit i (0..7) at E + BAUD_DIV/2 + (i+1)·BAUD_DIV;
  - stop bit at E + BAUD_DIV/2 + 9·BAUD_DIV.
- rdy, rx_data and frm_err update on the clock edge that ends the stop-sample cycle. They are visible on the next cycle.
- Back-to-back frames: a start edge arriving immediately after the stop bit is detected. The receiver is in IDLE 1 cycle after the stop sample, which leaves about half a bit of margin.
- Baud tolerance: the transmitter's clock may differ by up to ±4%.

## Structure
- Shared package uart_pkg holds:
  - localparam BAUD_DIV_DEFAULT = 5208, used by both the transmitter and this block;
  - typedef enum rx_state_t {IDLE, START, DATA, STOP}.
- Sub-module rx_sync: 2-flop synchroniser plus a previous-value flop. Outputs rx_s and fall.
- Everything else stays in uart_rx: FSM, baud counter, bit counter, shift register, output registers.
- Build the bench with BAUD_DIV = 16 for speed and run one test at 5208.

## Test plan
- Drive 8'hA5 with correct bit timing, then pulse clr_rdy → rx_data = 8'hA5 and rdy = 1 at E + 9.5·BAUD_DIV (±1 cycle); frm_err = 0; rdy = 0 the cycle after clr_rdy.
- Loop back through the team's transmitter, sending 8'h00, 8'hFF, 8'h55 and 8'h80 back-to-back with no idle gap → four bytes received in order, each setting rdy.
- RX low pulse of BAUD_DIV/4 cycles, then high → rdy stays 0, rx_data unchanged, FSM back in IDLE.
- Frame 8'h3C with stop bit = 0 → frm_err = 1, rdy = 0, rx_data = 8'h3C. A following good frame 8'h12 → frm_err = 0, rdy = 1.
- rst asserted mid-byte (after data bit 3) → all outputs at reset values immediately. The next full frame 8'hC3 is received correctly.
- clr_rdy pulsed in the same cycle rdy is set → rdy = 1.
